// File: rtl/prefix_scan_simd_if.sv
// Beat-in / result-out handshake bundle for the SIMD prefix scan unit.
// Both sides use valid/ready; the unit is the slave.
interface prefix_scan_simd_if #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 3
) ();
  logic                  in_v;
  logic                  in_ready;
  logic                  in_clear;
  logic [1:0]            in_mode;
  logic [TAGW-1:0]       in_tag;
  logic [LANES*DW-1:0]   in_data;
  logic                  out_v;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic [TAGW-1:0]       out_tag;
  logic [DW-1:0]         out_carry;

  modport slave (
    input  in_v, in_clear, in_mode, in_tag, in_data, out_ready,
    output in_ready, out_v, out_data, out_tag, out_carry
  );

  modport master (
    output in_v, in_clear, in_mode, in_tag, in_data, out_ready,
    input  in_ready, out_v, out_data, out_tag, out_carry
  );
endinterface

// File: rtl/prefix_scan_simd.sv
// Pipelined Kogge-Stone SIMD scan (add / exclusive add / unsigned max)
// with a running carry across beats and a stall-everything flow control.
module prefix_scan_simd #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 3
) (
  input logic               clk,
  input logic               reset,
  prefix_scan_simd_if.slave bus
);
  localparam int S = $clog2(LANES);
  localparam int W = LANES * DW;

  function automatic logic [DW-1:0] op(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [1:0]    m
  );
    if (m == 2'b10) return (a > b) ? a : b;
    return a + b;
  endfunction

  logic                  en;
  logic                  out_v_q;
  logic [W-1:0]          out_data_q, out_data_d;
  logic [TAGW-1:0]       out_tag_q;
  logic [DW-1:0]         carry_q, carry_d;
  logic [DW-1:0]         c;

  logic [S-1:0][W-1:0]    x_q, x_d;
  logic [S-1:0]           v_q, clr_q;
  logic [S-1:0][1:0]      mode_q;
  logic [S-1:0][TAGW-1:0] tag_q;

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic [S:0][W-1:0]    st;
  logic [S:0][1:0]      md;
  logic [S:0]           sv, sc;
  logic [S:0][TAGW-1:0] stg;

  assign en           = !out_v_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_v    = out_v_q;
  assign bus.out_data = out_data_q;
  assign bus.out_tag  = out_tag_q;
  assign bus.out_carry = carry_q;

  always_comb begin
    st[0]  = bus.in_data;
    md[0]  = bus.in_mode;
    sv[0]  = bus.in_v;
    sc[0]  = bus.in_clear;
    stg[0] = bus.in_tag;
    for (int k = 0; k < S; k++) begin
      st[k+1]  = x_q[k];
      md[k+1]  = mode_q[k];
      sv[k+1]  = v_q[k];
      sc[k+1]  = clr_q[k];
      stg[k+1] = tag_q[k];
    end
    x_d = '0;
    for (int k = 0; k < S; k++) begin
      for (int i = 0; i < LANES; i++) begin
        if (i >= (1 << k))
          x_d[k][i*DW +: DW] = op(
            st[k][i*DW +: DW],
            st[k][((i >= (1 << k)) ? i - (1 << k) : i)*DW +: DW],
            md[k]);
        else
          x_d[k][i*DW +: DW] = st[k][i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   v_q <= '0;
    else if (en) v_q <= sv[S-1:0];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x_q    <= x_d;
      mode_q <= md[S-1:0];
      clr_q  <= sc[S-1:0];
      tag_q  <= stg[S-1:0];
    end
  end

  always_comb begin
    c          = sc[S] ? '0 : carry_q;
    out_data_d = '0;
    unique case (1'b1)
      (md[S] == 2'b01): begin
        for (int i = 0; i < LANES; i++) begin
          if (i == 0)
            out_data_d[i*DW +: DW] = c;
          else
            out_data_d[i*DW +: DW] = op(
              c, st[S][((i == 0) ? 0 : i - 1)*DW +: DW], md[S]);
        end
      end
      default: begin
        for (int i = 0; i < LANES; i++)
          out_data_d[i*DW +: DW] = op(c, st[S][i*DW +: DW], md[S]);
      end
    endcase
    carry_d = op(c, st[S][(LANES-1)*DW +: DW], md[S]);
  end

  // Carry advances only when a valid beat lands in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      carry_q    <= '0;
    end else if (en) begin
      out_v_q <= sv[S];
      if (sv[S]) begin
        out_data_q <= out_data_d;
        out_tag_q  <= stg[S];
        carry_q    <= carry_d;
      end
    end
  end
endmodule

// File: tb/tb_prefix_scan_simd.sv
// Randomised + directed bench for prefix_scan_simd against a
// sequential scan model with an in-order scoreboard.
module tb_prefix_scan_simd;
  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int TAGW  = 3;
  localparam int W     = LANES * DW;

  typedef struct {
    logic [W-1:0]    data;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   carry;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prefix_scan_simd_if #(.LANES(LANES), .DW(DW), .TAGW(TAGW)) bus ();

  prefix_scan_simd #(.LANES(LANES), .DW(DW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t            exp_q[$];
  logic [DW-1:0]   carry_m = '0;
  logic [TAGW-1:0] tag_ctr = '0;
  int              checks = 0;
  int              errors = 0;
  int              rdy_mode = 0;

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Straight sequential scan: walk lanes, fold each into an accumulator.
  task automatic push_exp(input logic [W-1:0] d, input logic [1:0] m,
                          input logic clr, input logic [TAGW-1:0] tag);
    exp_t          e;
    logic [DW-1:0] acc, x;
    acc = clr ? '0 : carry_m;
    for (int i = 0; i < LANES; i++) begin
      x = d[i*DW +: DW];
      if (m == 2'b01) begin
        e.data[i*DW +: DW] = acc;
        acc = acc + x;
      end else if (m == 2'b10) begin
        acc = (x > acc) ? x : acc;
        e.data[i*DW +: DW] = acc;
      end else begin
        acc = acc + x;
        e.data[i*DW +: DW] = acc;
      end
    end
    carry_m = acc;
    e.tag   = tag;
    e.carry = acc;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("in_ready", W'(bus.in_ready), W'(!bus.out_v || bus.out_ready));
      if (bus.out_v && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("data", bus.out_data, e.data);
          chk("tag", W'(bus.out_tag), W'(e.tag));
          chk("carry", W'(bus.out_carry), W'(e.carry));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic [1:0] m,
                      input logic clr);
    bit acc;
    acc = 0;
    bus.in_v     = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_clear = clr;
    bus.in_tag   = tag_ctr;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(d, m, clr, tag_ctr);
        acc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", W'(0), W'(1));
    tag_ctr++;
    @(posedge clk);
    #1;
    bus.in_v = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (bus.out_v) begin
        n = t;
        break;
      end
    end
    if (n < 0) chk("out_timeout", W'(0), W'(1));
  endtask

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(i + 1);
    return d;
  endfunction

  function automatic logic [W-1:0] all_ones();
    logic [W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(1);
    return d;
  endfunction

  initial begin
    int           n;
    logic [W-1:0] d;
    int           vals [LANES] = '{3, 9, 2, 7, 1, 12, 5, 4};

    reset        = 1'b1;
    bus.in_v     = 1'b0;
    bus.in_clear = 1'b0;
    bus.in_mode  = 2'b00;
    bus.in_tag   = '0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_v", W'(bus.out_v), W'(0));
    chk("rst_out_data", bus.out_data, W'(0));
    chk("rst_out_tag", W'(bus.out_tag), W'(0));
    chk("rst_out_carry", W'(bus.out_carry), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;

    send(ramp(), 2'b00, 1'b1);
    wait_out(n);
    chk("latency", W'(n), W'(4));
    chk("t1_lane3", W'(bus.out_data[3*DW +: DW]), W'(10));
    chk("t1_carry", W'(bus.out_carry), W'(36));
    @(posedge clk);
    #1;

    send(all_ones(), 2'b00, 1'b0);
    wait_out(n);
    chk("t2_lane7", W'(bus.out_data[7*DW +: DW]), W'(44));
    @(posedge clk);
    #1;
    send(all_ones(), 2'b00, 1'b1);
    wait_out(n);
    chk("t2c_lane7", W'(bus.out_data[7*DW +: DW]), W'(8));
    @(posedge clk);
    #1;

    send(ramp(), 2'b01, 1'b1);
    wait_out(n);
    chk("excl_lane0", W'(bus.out_data[0 +: DW]), W'(0));
    chk("excl_carry", W'(bus.out_carry), W'(36));
    @(posedge clk);
    #1;

    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(vals[i]);
    send(d, 2'b10, 1'b1);
    wait_out(n);
    chk("max_lane2", W'(bus.out_data[2*DW +: DW]), W'(9));
    chk("max_carry", W'(bus.out_carry), W'(12));
    @(posedge clk);
    #1;

    d = '0;
    d[7*DW +: DW] = 32'hFFFF_FFFF;
    send(d, 2'b00, 1'b1);
    wait_out(n);
    @(posedge clk);
    #1;
    d = '0;
    d[0 +: DW] = 32'd1;
    send(d, 2'b00, 1'b0);
    wait_out(n);
    chk("wrap_lane0", W'(bus.out_data[0 +: DW]), W'(0));
    @(posedge clk);
    #1;

    send(ramp(), 2'b00, 1'b0);
    send(all_ones(), 2'b01, 1'b0);
    send(ramp(), 2'b00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_v", W'(bus.out_v), W'(0));
    exp_q.delete();
    carry_m = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    send(ramp(), 2'b00, 1'b0);
    wait_out(n);
    chk("postrst_carry", W'(bus.out_carry), W'(36));
    @(posedge clk);
    #1;

    fork
      begin
        for (int b = 0; b < 6; b++) send(ramp(), 2'(b % 3), b == 0);
      end
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join

    rdy_mode = 2;
    for (int b = 0; b < 300; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < LANES; i++)
        d[i*DW +: DW] = $urandom_range(0, 1) ? DW'($urandom)
                                             : DW'($urandom_range(0, 20));
      send(d, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end

    rdy_mode = 0;
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
